// File: rtl/output_collector_if.sv
// output_collector_if: result stream returned to the host.
// m_data/m_last are valid while m_valid is high; a word moves when m_valid && m_ready.
interface output_collector_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/output_collector.sv
// output_collector: buffers the upstream result stream in a FIFO and hands it
// back to the host, tagging the last word of each announced frame.
// Optional COLLECT watchdog is built only when OUT_COLLECT_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for an out_count announcement
// COLLECT | pushing y_valid words, remaining counts down to the last word
// DRAIN   | input closed; waiting for the FIFO to empty, then frame_done
module output_collector #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] y_data,
    input  logic              y_valid,
    input  logic [DATA_W-1:0] out_count,
    input  logic              out_count_valid,
    input  logic              clear_err,
    output_collector_if.master m_if,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              proto_err,
    output logic              timeout
);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [DATA_W-1:0] REM_ONE  = DATA_W'(1);

    if (DEPTH < 2 || (1 << ADDR_W) != DEPTH || TIMEOUT < 1) begin : g_param_check
        $error("output_collector: DEPTH must be 2**ADDR_W and >= 2, TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [DATA_W-1:0] remaining_q, remaining_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;
    logic              proto_err_q, proto_err_d;
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   rd_entry;
    logic              y_acc, oc_acc, full, pop;
    logic              push_req, push_ok, push_last, proto_set;
    logic              wdog_fire;

    assign y_acc        = enable & y_valid;
    assign oc_acc       = enable & out_count_valid;
    assign full         = (level_q == LVL_FULL);
    assign rd_entry     = mem_q[rd_ptr_q];
    assign m_if.m_valid = (level_q != '0);
    assign m_if.m_data  = rd_entry[DATA_W-1:0];
    assign m_if.m_last  = m_if.m_valid & rd_entry[DATA_W];
    assign pop          = m_if.m_valid & m_if.m_ready;
    // Full is judged on the registered level, so a pop never makes room for a same-cycle push
    assign push_ok      = push_req & ~full;

    // Frame sequencing: next state, remaining count, push request and protocol errors
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        frame_done_d = 1'b0;
        push_req     = 1'b0;
        push_last    = 1'b0;
        proto_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (oc_acc) begin
                    if (out_count != '0) begin
                        remaining_d = out_count;
                        state_d     = ST_COLLECT;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
                if (y_acc) proto_set = 1'b1;
            end
            ST_COLLECT: begin
                if (y_acc) begin
                    push_req  = 1'b1;
                    push_last = (remaining_q == REM_ONE);
                    if (remaining_q != '0) remaining_d = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) state_d = ST_DRAIN;
                end else if (wdog_fire) begin
                    // Abandoned frame: drain what arrived, no word carries the last tag
                    remaining_d = '0;
                    state_d     = ST_DRAIN;
                end
                if (oc_acc) proto_set = 1'b1;
            end
            ST_DRAIN: begin
                if (y_acc || oc_acc) proto_set = 1'b1;
                if (level_q == '0 || (level_q == LVL_ONE && pop)) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointers, occupancy and sticky error flags (a new event beats clear_err)
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        overflow_d  = (overflow_q & ~clear_err) | (push_req & full);
        proto_err_d = (proto_err_q & ~clear_err) | proto_set;
    end

    // Control and status registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            remaining_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            remaining_q  <= remaining_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // FIFO storage: data plus last tag, no reset needed since level gates the read side
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {push_last, y_data};
    end

`ifdef OUT_COLLECT_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_q, timeout_d;

    assign wdog_fire = (state_q == ST_COLLECT) && !y_acc && (wdog_q == '0);

    // Watchdog: reloaded outside COLLECT and on every accepted word, counts idle COLLECT cycles
    always_comb begin
        wdog_d    = wdog_q;
        if (state_q != ST_COLLECT || y_acc) wdog_d = WD_LOAD;
        else if (wdog_q != '0)              wdog_d = wdog_q - WD_ONE;
        timeout_d = (timeout_q & ~clear_err) | wdog_fire;
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wdog_q    <= WD_LOAD;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wdog_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign proto_err  = proto_err_q;
endmodule

// File: tb/tb_output_collector.sv
`timescale 1ns/1ps
module tb_output_collector;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              clear_n = 1'b0;
    logic              enable = 1'b0;
    logic [DATA_W-1:0] y_data = '0;
    logic              y_valid = 1'b0;
    logic [DATA_W-1:0] out_count = '0;
    logic              out_count_valid = 1'b0;
    logic              clear_err = 1'b0;
    logic              busy, frame_done, overflow, proto_err, timeout;
    logic [ADDR_W:0]   level;

    output_collector_if #(.DATA_W(DATA_W)) m_if ();

    output_collector #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .clear_n(clear_n), .enable(enable),
        .y_data(y_data), .y_valid(y_valid),
        .out_count(out_count), .out_count_valid(out_count_valid),
        .clear_err(clear_err), .m_if(m_if),
        .busy(busy), .frame_done(frame_done), .level(level),
        .overflow(overflow), .proto_err(proto_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO as a queue of {last, data}, frame phase as a plain integer
    // (0 idle, 1 collecting, 2 draining), idle cycles counted upward for the watchdog.
    logic [DATA_W:0] mq[$];
    int     md_mode;
    longint md_rem;
    int     md_idle;
    bit     md_fd, md_ovf, md_perr, md_tmo;

    logic [DATA_W-1:0] got_data [64];
    logic              got_last [64];

    task automatic model_reset();
        mq.delete();
        md_mode = 0; md_rem = 0; md_idle = 0;
        md_fd = 0; md_ovf = 0; md_perr = 0; md_tmo = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit pop, full, fd_n, pset, oset, tset, do_push;
        int nmode;
        logic [DATA_W:0] pword;
        pop = (mq.size() != 0) && (m_if.m_ready === 1'b1);
        full = (mq.size() == DEPTH);
        fd_n = 0; pset = 0; oset = 0; tset = 0; do_push = 0; pword = '0;
        nmode = md_mode;
        case (md_mode)
            0: begin
                if (enable && out_count_valid) begin
                    if (out_count != 0) begin
                        md_rem = out_count; md_idle = 0; nmode = 1;
                    end else fd_n = 1;
                end
                if (enable && y_valid) pset = 1;
            end
            1: begin
                if (enable && y_valid) begin
                    if (full) oset = 1;
                    else begin
                        do_push = 1;
                        pword = {(md_rem == 1) ? 1'b1 : 1'b0, y_data};
                    end
                    md_rem = md_rem - 1;
                    if (md_rem == 0) nmode = 2;
                    md_idle = 0;
                end else begin
`ifdef OUT_COLLECT_TIMEOUT_EN
                    if (md_idle == TIMEOUT) begin
                        tset = 1; nmode = 2; md_rem = 0;
                    end else md_idle = md_idle + 1;
`endif
                end
                if (enable && out_count_valid) pset = 1;
            end
            default: begin
                if (enable && (y_valid || out_count_valid)) pset = 1;
                if (mq.size() == 0 || (mq.size() == 1 && pop)) begin
                    fd_n = 1; nmode = 0;
                end
            end
        endcase
        if (pop) void'(mq.pop_front());
        if (do_push) mq.push_back(pword);
        md_ovf  = (md_ovf  && !clear_err) || oset;
        md_perr = (md_perr && !clear_err) || pset;
        md_tmo  = (md_tmo  && !clear_err) || tset;
        md_fd   = fd_n;
        md_mode = nmode;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        y_valid = 0; out_count_valid = 0; clear_err = 0; enable = 1;
    endtask

    // Drain with m_ready high until frame_done (bounded); records the words seen
    task automatic drain(output int n, output bit done, output int gap);
        n = 0; done = 0; gap = 0;
        m_if.m_ready = 1'b1;
        for (int c = 0; c < 64; c++) begin
            if (frame_done === 1'b1) begin
                done = 1;
                break;
            end
            if (m_if.m_valid === 1'b1) begin
                got_data[n] = m_if.m_data;
                got_last[n] = m_if.m_last;
                n++;
            end else gap++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [11:0] got;
        model_reset();
        m_if.m_ready = 1'b0;
        clear_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {m_if.m_valid, m_if.m_last, busy, frame_done, overflow, proto_err, timeout, level};
        checks++;
        if (got !== 12'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", got, 12'b0);
        end
        clear_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_basic_frame();
        logic [DATA_W-1:0] w [3];
        w[0] = 32'hA; w[1] = 32'hB; w[2] = 32'hC;
        m_if.m_ready = 1'b1;
        out_count = 3; out_count_valid = 1; tick();
        out_count_valid = 0;
        checks++;
        if (busy !== 1'b1 || level !== 5'd0) begin
            errors++;
            $display("FAIL basic_start: busy=%b level=%0d expected busy=1 level=0", busy, level);
        end
        for (int i = 0; i < 3; i++) begin
            y_valid = 1; y_data = w[i]; tick();
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== w[i] || m_if.m_last !== (i == 2)) begin
                errors++;
                $display("FAIL basic_word%0d: valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                         i, m_if.m_valid, m_if.m_data, m_if.m_last, w[i], (i == 2));
            end
        end
        y_valid = 0; tick();
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: frame_done=%b busy=%b m_valid=%b expected 1 0 0", frame_done, busy, m_if.m_valid);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: frame_done=%b expected 0", frame_done);
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] w [20];
        int n, gap;
        bit done;
        m_if.m_ready = 1'b0;
        out_count = 20; out_count_valid = 1; tick();
        out_count_valid = 0;
        for (int i = 0; i < 20; i++) begin
            w[i] = $urandom();
            y_valid = 1; y_data = w[i]; tick();
        end
        y_valid = 0;
        checks++;
        if (level !== 5'd16 || overflow !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_fill: level=%0d overflow=%b busy=%b expected 16 1 1", level, overflow, busy);
        end
        drain(n, done, gap);
        checks++;
        if (!done || n != 16 || gap != 0 || level !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain: done=%0d words=%0d gaps=%0d level=%0d busy=%b expected 1 16 0 0 0",
                     done, n, gap, level, busy);
        end
        for (int i = 0; i < n && i < 16; i++) begin
            checks++;
            if (got_data[i] !== w[i] || got_last[i] !== 1'b0) begin
                errors++;
                $display("FAIL ovf_word%0d: data=%h last=%b expected data=%h last=0", i, got_data[i], got_last[i], w[i]);
            end
        end
        clear_err = 1; tick(); clear_err = 0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%b expected 0", overflow);
        end
    endtask

    task automatic test_zero_count();
        out_count = 0; out_count_valid = 1; tick();
        out_count_valid = 0;
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL zero_count: frame_done=%b busy=%b level=%0d expected 1 0 0", frame_done, busy, level);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_count_pulse: frame_done=%b expected 0", frame_done);
        end
    endtask

    task automatic test_idle_yvalid();
        y_valid = 1; y_data = 32'h1234; tick();
        y_valid = 0;
        checks++;
        if (proto_err !== 1'b1 || level !== 5'd0) begin
            errors++;
            $display("FAIL idle_yvalid: proto_err=%b level=%0d expected 1 0", proto_err, level);
        end
        clear_err = 1; tick(); clear_err = 0;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_clear: proto_err=%b expected 0", proto_err);
        end
        y_valid = 1; clear_err = 1; tick();
        y_valid = 0; clear_err = 0;
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: proto_err=%b expected 1", proto_err);
        end
        clear_err = 1; tick(); clear_err = 0;
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] got;
        m_if.m_ready = 1'b0;
        out_count = 8; out_count_valid = 1; tick();
        out_count_valid = 0;
        for (int i = 0; i < 5; i++) begin
            y_valid = 1; y_data = $urandom(); tick();
        end
        y_valid = 0;
        checks++;
        if (level !== 5'd5) begin
            errors++;
            $display("FAIL mid_level: level=%0d expected 5", level);
        end
        @(posedge clk);
        #2 clear_n = 1'b0;
        model_reset();
        #1;
        got = {m_if.m_valid, m_if.m_last, busy, frame_done, overflow, proto_err, timeout, level};
        checks++;
        if (got !== 12'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b expected %b", got, 12'b0);
        end
        @(negedge clk);
        clear_n = 1'b1;
        tick();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: frame_done=%b busy=%b expected 0 0", frame_done, busy);
        end
        out_count = 1; out_count_valid = 1; tick();
        out_count_valid = 0;
        y_valid = 1; y_data = 32'hCAFE_0001; tick();
        y_valid = 0;
        checks++;
        if (m_if.m_valid !== 1'b1 || m_if.m_data !== 32'hCAFE_0001 || m_if.m_last !== 1'b1) begin
            errors++;
            $display("FAIL mid_newframe: valid=%b data=%h last=%b expected 1 cafe0001 1",
                     m_if.m_valid, m_if.m_data, m_if.m_last);
        end
        m_if.m_ready = 1'b1; tick();
        checks++;
        if (frame_done !== 1'b1 || level !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_newdone: frame_done=%b level=%0d busy=%b expected 1 0 0", frame_done, level, busy);
        end
    endtask

`ifdef OUT_COLLECT_TIMEOUT_EN
    task automatic test_timeout();
        int n, gap;
        bit done;
        m_if.m_ready = 1'b0;
        out_count = 4; out_count_valid = 1; tick();
        out_count_valid = 0;
        for (int i = 0; i < 2; i++) begin
            y_valid = 1; y_data = 32'h100 + i; tick();
        end
        y_valid = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 8) begin
                checks++;
                if (timeout !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_early: timeout=%b busy=%b expected 0 1", timeout, busy);
                end
            end
            if (k == 9) begin
                checks++;
                if (timeout !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_fire: timeout=%b expected 1", timeout);
                end
            end
        end
        drain(n, done, gap);
        checks++;
        if (!done || n != 2 || got_last[0] !== 1'b0 || got_last[1] !== 1'b0 || got_data[1] !== 32'h101) begin
            errors++;
            $display("FAIL tmo_drain: done=%0d words=%0d last0=%b last1=%b data1=%h expected 1 2 0 0 101",
                     done, n, got_last[0], got_last[1], got_data[1]);
        end
        clear_err = 1; tick(); clear_err = 0;
    endtask
`else
    task automatic test_no_timeout();
        int n, gap;
        bit done;
        m_if.m_ready = 1'b0;
        out_count = 2; out_count_valid = 1; tick();
        out_count_valid = 0;
        y_valid = 1; y_data = 32'h55; tick();
        y_valid = 0;
        repeat (40) tick();
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1 || level !== 5'd1) begin
            errors++;
            $display("FAIL no_tmo_wait: timeout=%b busy=%b level=%0d expected 0 1 1", timeout, busy, level);
        end
        y_valid = 1; y_data = 32'h66; tick();
        y_valid = 0;
        drain(n, done, gap);
        checks++;
        if (!done || n != 2 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1 || got_data[1] !== 32'h66) begin
            errors++;
            $display("FAIL no_tmo_drain: done=%0d words=%0d last0=%b last1=%b data1=%h expected 1 2 0 1 66",
                     done, n, got_last[0], got_last[1], got_data[1]);
        end
    endtask
`endif

    task automatic test_random();
        logic [11:0] got, exp;
        for (int c = 0; c < 1500; c++) begin
            exp = {(mq.size() != 0), 1'b0, (md_mode != 0), md_fd, md_ovf, md_perr, md_tmo, (ADDR_W + 1)'(mq.size())};
            got = {m_if.m_valid, 1'b0, busy, frame_done, overflow, proto_err, timeout, level};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_status cycle %0d: got %b expected %b", c, got, exp);
            end
            if (mq.size() != 0) begin
                checks++;
                if ({m_if.m_last, m_if.m_data} !== mq[0]) begin
                    errors++;
                    $display("FAIL random_head cycle %0d: got %h expected %h", c, {m_if.m_last, m_if.m_data}, mq[0]);
                end
            end
            enable = ($urandom_range(0, 9) != 0);
            m_if.m_ready = ($urandom_range(0, 99) < 55);
            clear_err = ($urandom_range(0, 99) < 4);
            y_data = $urandom();
            out_count = $urandom_range(0, 20);
            if (md_mode == 0) begin
                out_count_valid = ($urandom_range(0, 99) < 15);
                y_valid = ($urandom_range(0, 99) < 4);
            end else if (md_mode == 1) begin
                out_count_valid = ($urandom_range(0, 99) < 3);
                y_valid = ($urandom_range(0, 99) < 75);
            end else begin
                out_count_valid = ($urandom_range(0, 99) < 3);
                y_valid = ($urandom_range(0, 99) < 4);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not complete within the time budget");
        $fatal(1, "time limit reached");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow();
        test_zero_count();
        test_idle_yvalid();
        test_reset_mid_frame();
`ifdef OUT_COLLECT_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_collector.md
Name: output_collector

Overview:
- Sits directly downstream of the host-facing data interface.
- Consumes the registered result stream (y_data/y_valid) and the per-frame expected-length announcement (out_count/out_count_valid).
- Buffers result words in a FIFO and returns them to the host over a valid/ready stream, tagging the last word of each frame.
- Reports frame completion, overflow and protocol errors.

Parameters:
- DATA_W, 32, width of result words and of out_count.
- DEPTH, 16, FIFO depth in words; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- TIMEOUT, 1024, idle cycles allowed in COLLECT. Used only with OUT_COLLECT_TIMEOUT_EN.

Ports:
- clk  in  1  global clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- enable  in  1  global enable; gates the input side only.
- y_data  in  DATA_W  result word from the upstream stage.
- y_valid  in  1  y_data valid this cycle.
- out_count  in  DATA_W  expected number of result words for the next frame.
- out_count_valid  in  1  out_count valid this cycle.
- clear_err  in  1  synchronous pulse; clears the sticky error flags.
- m_data  out  DATA_W  output word (head of FIFO).
- m_valid  out  1  m_data valid.
- m_ready  in  1  host accepts m_data.
- m_last  out  1  m_data is the final word of its frame.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse when a frame has fully drained.
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- proto_err  out  1  sticky: y_valid arrived in IDLE, or out_count_valid arrived while busy.
- timeout  out  1  sticky: COLLECT watchdog expired. Tied 0 without the macro.

Behaviour:
- Reset (clear_n low, asynchronous) sets:
  - state IDLE; FIFO pointers 0; level 0; remaining 0.
  - m_valid 0, m_last 0, busy 0, frame_done 0, overflow 0, proto_err 0, timeout 0.
  - Reset mid-frame discards all buffered words; no frame_done is issued.
- FIFO:
  - Storage is DATA_W+1 bits wide (data plus last tag).
  - m_data and m_last are read combinationally at the read pointer. m_valid = (level != 0).
  - Pop when m_valid && m_ready.
  - Pointers are ADDR_W bits and wrap modulo DEPTH.
  - Full is level == DEPTH and is evaluated on the registered level. A push while full is dropped even if a pop occurs in the same cycle; the pop still happens.
  - Simultaneous push and pop when not full leaves level unchanged.
- Latency: a word accepted at edge N is visible on m_data with m_valid=1 after edge N (zero extra cycles).
- Output side runs regardless of enable and state.
- Input side samples y_valid and out_count_valid only when enable=1.
- IDLE:
  - out_count_valid with out_count != 0: remaining <= out_count; go to COLLECT.
  - out_count_valid with out_count == 0: frame_done pulses next cycle; stay IDLE.
  - y_valid: word ignored; proto_err <= 1.
- COLLECT:
  - Each y_valid pushes {last=(remaining==1), y_data} and decrements remaining, whether or not the push was dropped.
  - When remaining==1 and y_valid: go to DRAIN.
  - out_count_valid: ignored; proto_err <= 1.
- DRAIN:
  - Collection stops; a y_valid here sets proto_err and the word is dropped.
  - When level==0, or level==1 with a pop this cycle: pulse frame_done, go to IDLE.
  - out_count_valid in DRAIN sets proto_err; it is not queued.
- remaining is DATA_W wide and never underflows. The decrement occurs only in COLLECT.
- Sticky flags:
  - Cleared only by reset or clear_err.
  - If clear_err coincides with a new error event, the set wins.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro OUT_COLLECT_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on entry to COLLECT and on every accepted y_valid, and increments each cycle in COLLECT.
  - On reaching TIMEOUT: timeout <= 1; go to DRAIN without a last tag; frame_done pulses when the FIFO empties; remaining cleared.
- Undefined: no counter is built; timeout is tied 0; COLLECT waits indefinitely.

Test Plan:
- out_count=3, then y_data 0xA,0xB,0xC on consecutive cycles, m_ready=1 -> m_data 0xA,0xB,0xC with m_last only on 0xC; frame_done one cycle after 0xC pops; busy falls with it.
- out_count=20, DEPTH=16, m_ready=0 for 20 words -> level saturates at 16, overflow=1, state reaches DRAIN; raising m_ready yields 16 words, no m_last on any, frame_done after the last pop.
- out_count=0 in IDLE -> frame_done pulse, busy stays 0, level 0.
- y_valid in IDLE -> proto_err=1, level 0; clear_err pulse -> proto_err=0.
- Reset asserted mid-COLLECT with level=5 -> all outputs at reset values immediately, no frame_done; a new out_count=1 frame completes normally.
- With OUT_COLLECT_TIMEOUT_EN, TIMEOUT=8: out_count=4, two words, then silence -> timeout=1 nine cycles later, both words drain without m_last, frame_done pulses.
